// File: rtl/urv_defs.sv
`default_nettype none
// ============================================================================
//  Module      : urv_defs (package)
//  Description : Shared definitions for the uRV data-memory path: load/store
//                size codes and the access-sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package urv_defs;

    // Load/store size codes carried on x_fun_i
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

endpackage : urv_defs
`default_nettype wire

// File: rtl/urv_dmem_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dmem_lanes
//  Description : Byte-lane generation for data-memory accesses. Produces the
//                byte enables, lane-replicated store data and the misaligned
//                flag from the size code and the low address bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_dmem_lanes
    import urv_defs::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_value_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    // Lane decode; unknown size codes are treated as full-word accesses
    always_comb begin
        sel_o        = 4'b1111;
        wdata_o      = store_value_i;
        misaligned_o = 1'b0;
        case (fun_i)
            LDST_B, LDST_BU: begin
                sel_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_value_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                sel_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{store_value_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

endmodule : urv_dmem_lanes
`default_nettype wire

// File: rtl/urv_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dmem_ctrl
//  Description : Data-memory access sequencer. Converts an execute-stage
//                load/store into one held bus cycle, returns one-cycle done
//                pulses plus the raw load word, and flags misalignment, bus
//                errors and bus timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_dmem_ctrl
    import urv_defs::*;
#(
    parameter int unsigned g_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] x_store_value_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_fault_o,
    output logic        dm_misaligned_o
);

    localparam logic [15:0] TIMEOUT_CYC = 16'(g_timeout);

    dmem_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_cyc_q, bus_cyc_d;
    logic        is_load_q, is_load_d;
    logic [31:0] data_l_q, data_l_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;
    logic        fault_q, fault_d;
    logic        misaligned_q, misaligned_d;

    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic        lane_misaligned;
    logic        req;

    urv_dmem_lanes u_lanes (
        .fun_i         (x_fun_i),
        .addr_lo_i     (x_dm_addr_i[1:0]),
        .store_value_i (x_store_value_i),
        .sel_o         (lane_sel),
        .wdata_o       (lane_wdata),
        .misaligned_o  (lane_misaligned)
    );

    assign req = x_valid_i & (x_load_i | x_store_i);

    // Next-state logic: issue, hold and retire a single bus cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_sel_d    = bus_sel_q;
        bus_we_d     = bus_we_q;
        bus_cyc_d    = bus_cyc_q;
        is_load_d    = is_load_q;
        data_l_d     = data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;
        fault_d      = 1'b0;
        misaligned_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    is_load_d = x_load_i;
                    if (lane_misaligned) begin
                        // Retire immediately without touching the bus
                        state_d      = ST_DONE;
                        load_done_d  = x_load_i;
                        store_done_d = x_store_i;
                        fault_d      = 1'b1;
                        misaligned_d = 1'b1;
                        if (x_load_i) data_l_d = 32'd0;
                    end else begin
                        state_d     = ST_BUSY;
                        cnt_d       = 16'd0;
                        bus_addr_d  = {x_dm_addr_i[31:2], 2'b00};
                        bus_wdata_d = lane_wdata;
                        bus_sel_d   = lane_sel;
                        bus_we_d    = x_store_i;
                        bus_cyc_d   = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                // cyc already dropped means the timeout abort cycle
                if (bus_cyc_q && !bus_err_i && !bus_ack_i) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q + 16'd1 == TIMEOUT_CYC) begin
                        bus_cyc_d = 1'b0;
                        bus_sel_d = 4'd0;
                        bus_we_d  = 1'b0;
                    end
                end else begin
                    state_d      = ST_DONE;
                    bus_cyc_d    = 1'b0;
                    bus_sel_d    = 4'd0;
                    bus_we_d     = 1'b0;
                    load_done_d  = is_load_q;
                    store_done_d = ~is_load_q;
                    if (bus_cyc_q && !bus_err_i) begin
                        if (is_load_q) data_l_d = bus_rdata_i;
                    end else begin
                        fault_d = 1'b1;
                        if (is_load_q) data_l_d = 32'd0;
                    end
                end
            end

            ST_DONE: begin
                // The request still visible here is the retiring instruction
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            bus_sel_q    <= 4'd0;
            bus_we_q     <= 1'b0;
            bus_cyc_q    <= 1'b0;
            is_load_q    <= 1'b0;
            data_l_q     <= 32'd0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            fault_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_sel_q    <= bus_sel_d;
            bus_we_q     <= bus_we_d;
            bus_cyc_q    <= bus_cyc_d;
            is_load_q    <= is_load_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            fault_q      <= fault_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus_addr_o      = bus_addr_q;
    assign bus_wdata_o     = bus_wdata_q;
    assign bus_sel_o       = bus_sel_q;
    assign bus_we_o        = bus_we_q;
    assign bus_cyc_o       = bus_cyc_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_fault_o      = fault_q;
    assign dm_misaligned_o = misaligned_q;

endmodule : urv_dmem_ctrl
`default_nettype wire
